// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter; define PS2_TX_ACK_CHECK_EN to turn a missing device ACK into tx_error.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE
);
  localparam int CW = $clog2((TIMEOUT_CYCLES > INHIBIT_CYCLES ? TIMEOUT_CYCLES : INHIBIT_CYCLES) + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic [CW-1:0] cnt;
  logic [3:0] bit_cnt;
  logic [8:0] sr;
  logic clk_s, data_s, clk_prev, fall, accept, shift, timeout, ack_bad, nack, done_n, err_n;
  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign data_s   = data_sync[SYNC_STAGES-1];
  assign fall     = clk_prev & ~clk_s;
  assign tx_ready = state == IDLE;
  assign busy     = ~tx_ready;
  assign accept   = tx_valid & tx_ready;
  assign shift    = fall & (state == REQUEST || state == SHIFT);
  assign timeout  = cnt == CW'(TIMEOUT_CYCLES - 1);
`ifdef PS2_TX_ACK_CHECK_EN
  assign ack_bad = data_s;
`else
  assign ack_bad = 1'b0;
`endif
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE:    state_n = accept ? INHIBIT : IDLE;
      INHIBIT: state_n = (cnt == CW'(INHIBIT_CYCLES - 1)) ? REQUEST : INHIBIT;
      REQUEST, SHIFT, ACK:
        if (fall)
          state_n = (state == REQUEST) ? SHIFT : (state == ACK) ? WAIT_IDLE : (bit_cnt == 4'd9) ? ACK : SHIFT;
        else if (timeout) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      WAIT_IDLE:
        if (clk_s & data_s) begin
          state_n = IDLE;
          done_n  = ~nack;
          err_n   = nack;
        end else if (timeout) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      clk_sync    <= '1;
      data_sync   <= '1;
      clk_prev    <= 1'b1;
      cnt         <= '0;
      bit_cnt     <= '0;
      sr          <= '0;
      nack        <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      PS2_CLK_OE  <= 1'b0;
      PS2_DATA_OE <= 1'b0;
    end else begin
      state      <= state_n;
      clk_sync   <= SYNC_STAGES'({clk_sync, PS2_CLK_IN});
      data_sync  <= SYNC_STAGES'({data_sync, PS2_DATA_IN});
      clk_prev   <= clk_s;
      // edges seen while we hold the clock low ourselves must not stretch the inhibit window
      cnt        <= (state == IDLE || state_n != state || (fall && state != INHIBIT)) ? '0 : cnt + 1'b1;
      tx_done    <= done_n;
      tx_error   <= err_n;
      PS2_CLK_OE <= state_n == INHIBIT;
      if (accept) begin
        sr      <= {~^tx_data, tx_data};
        bit_cnt <= '0;
        nack    <= 1'b0;
      end else if (shift) begin
        sr      <= {1'b1, sr[8:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (state == ACK && fall) nack <= ack_bad;
      // ones shifted in behind the parity bit make the tenth edge release data as the stop bit
      if (state_n == IDLE) PS2_DATA_OE <= 1'b0;
      else if (state == INHIBIT && state_n == REQUEST) PS2_DATA_OE <= 1'b1;
      else if (shift) PS2_DATA_OE <= ~sr[0];
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: table, random and hand-written sequences against an open-drain PS/2 device model.
module tb_ps2_host_tx;
  localparam int INH  = 20;
  localparam int TO   = 200;
  localparam int HALF = 8;
  logic CLK = 1'b0, RST = 1'b1;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_ready, busy, tx_done, tx_error, PS2_CLK_OE, PS2_DATA_OE;
  logic dev_clk = 1'b1, dev_data = 1'b1;
  logic line_clk, line_data;
  int tests = 0, failed = 0;
  int done_cnt = 0, err_cnt = 0, inh_cnt = 0, both_cnt = 0;
  int s_done, s_err, s_inh;
  assign line_clk  = dev_clk & ~PS2_CLK_OE;
  assign line_data = dev_data & ~PS2_DATA_OE;
  always #5 CLK = ~CLK;
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .tx_done(tx_done), .tx_error(tx_error), .PS2_CLK_IN(line_clk),
    .PS2_DATA_IN(line_data), .PS2_CLK_OE(PS2_CLK_OE), .PS2_DATA_OE(PS2_DATA_OE)
  );
  always @(negedge CLK) begin
    if (PS2_CLK_OE) inh_cnt <= inh_cnt + 1;
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
  end
  typedef struct {
    logic [7:0] d;
    logic       ack_low;
    logic [9:0] exp_bits;
    int         exp_done;
    int         exp_err;
  } vec_t;
  vec_t vecs[6];
  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // line levels the device should sample after falls 1..10: data LSB first, odd parity, stop
  function automatic logic [9:0] expect_bits(input logic [7:0] d);
    logic [9:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[i];
    r[8] = ($countones(d) % 2) == 0;
    r[9] = 1'b1;
    return r;
  endfunction
  function automatic int nack_err();
`ifdef PS2_TX_ACK_CHECK_EN
    return 1;
`else
    return 0;
`endif
  endfunction
  task automatic snap();
    s_done = done_cnt;
    s_err  = err_cnt;
    s_inh  = inh_cnt;
  endtask
  task automatic send(input logic [7:0] d);
    int t = 0;
    while (!tx_ready && t < 1000) begin @(negedge CLK); t++; end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge CLK);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask
  task automatic dev_xfer(input logic ack_low, input int n, output logic [10:0] seen, output logic started);
    int t = 0;
    seen = '0;
    while (!(line_clk && !line_data && !PS2_CLK_OE) && t < 2000) begin @(negedge CLK); t++; end
    started = t < 2000;
    if (started) begin
      repeat (4) @(negedge CLK);
      for (int k = 1; k <= n; k++) begin
        dev_clk = 1'b0;
        if (k == 11 && ack_low) dev_data = 1'b0;
        repeat (HALF) @(negedge CLK);
        seen[k-1] = line_data;
        dev_clk = 1'b1;
        repeat (HALF) @(negedge CLK);
        dev_data = 1'b1;
      end
    end
  endtask
  task automatic verify(input string nm, input logic [9:0] eb, input logic [10:0] seen, input logic started,
                        input int edone, input int eerr);
    repeat (12) @(negedge CLK);
    check({nm, "_start"}, int'(started), 1);
    check({nm, "_bits"}, int'(seen[9:0]), int'(eb));
    check({nm, "_inhibit"}, inh_cnt - s_inh, INH);
    check({nm, "_done"}, done_cnt - s_done, edone);
    check({nm, "_err"}, err_cnt - s_err, eerr);
    check({nm, "_ready"}, int'(tx_ready), 1);
  endtask
  task automatic run_txn(input string nm, input logic [7:0] d, input logic ack, input logic [9:0] eb,
                         input int edone, input int eerr);
    logic [10:0] seen;
    logic started;
    snap();
    send(d);
    dev_xfer(ack, 11, seen, started);
    verify(nm, eb, seen, started, edone, eerr);
  endtask
  initial begin
    logic [10:0] seen;
    logic started;
    logic [7:0] d;
    logic ack;
    int t;
    vecs[0] = '{8'hED, 1'b1, 10'h3ED, 1, 0};
    vecs[1] = '{8'hF4, 1'b1, 10'h2F4, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 10'h3FF, 1, 0};
    vecs[3] = '{8'h00, 1'b1, 10'h300, 1, 0};
    vecs[4] = '{8'h01, 1'b1, 10'h201, 1, 0};
    vecs[5] = '{8'hED, 1'b0, 10'h3ED, 1 - nack_err(), nack_err()};
    repeat (3) @(negedge CLK);
    check("reset_state", int'({tx_ready, busy, PS2_CLK_OE, PS2_DATA_OE, tx_done, tx_error}), 32);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i].d, vecs[i].ack_low, vecs[i].exp_bits,
                              vecs[i].exp_done, vecs[i].exp_err);
    for (int i = 0; i < 6; i++) begin
      d   = 8'($urandom);
      ack = 1'($urandom_range(0, 1));
      run_txn($sformatf("rnd%0d_%02h", i, d), d, ack, expect_bits(d), ack ? 1 : 1 - nack_err(), ack ? 0 : nack_err());
    end
    // device never clocks: error exactly TO cycles after request entry
    snap();
    send(8'hF4);
    t = 0;
    while (!PS2_DATA_OE && t < 500) begin @(negedge CLK); t++; end
    t = 0;
    while (!tx_error && t < 1000) begin @(negedge CLK); t++; end
    check("timeout_cycles", t, TO);
    check("timeout_oe", int'({PS2_CLK_OE, PS2_DATA_OE}), 0);
    repeat (3) @(negedge CLK);
    check("timeout_err", err_cnt - s_err, 1);
    check("timeout_done", done_cnt - s_done, 0);
    // reset at the fifth device edge of a 0xFF send
    send(8'hFF);
    dev_xfer(1'b1, 4, seen, started);
    dev_clk = 1'b0;
    repeat (5) @(negedge CLK);
    check("rst_busy_before", int'(busy), 1);
    snap();
    RST = 1'b1;
    #1;
    check("rst_oe", int'({PS2_CLK_OE, PS2_DATA_OE, tx_ready}), 1);
    dev_clk = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    check("rst_no_pulse", (done_cnt - s_done) + (err_cnt - s_err), 0);
    run_txn("after_rst", 8'hF4, 1'b1, 10'h2F4, 1, 0);
    // request while busy is dropped
    snap();
    send(8'hED);
    fork
      dev_xfer(1'b1, 11, seen, started);
      begin
        repeat (60) @(negedge CLK);
        check("busy_during", int'(busy), 1);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge CLK);
        tx_valid = 1'b0;
      end
    join
    verify("busy_ignore", 10'h3ED, seen, started, 1, 0);
    repeat (40) @(negedge CLK);
    check("busy_no_second", inh_cnt - s_inh, INH);
    check("exclusive", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends command bytes to the keyboard, such as 0xED (set LEDs), 0xFF (reset) and 0xF4 (enable).
- Shares the PS/2 clock/data pins with the existing PS/2 receive path through open-drain enables.
- Owns bus-request signalling, bit serialisation, odd-parity generation, ACK detection and timeout recovery.
- Asserts busy so the receive path ignores bus activity while a command is in flight.

Parameters:
- INHIBIT_CYCLES, 2500: CLK cycles the host holds PS2 clock low before requesting to send; 100 us at 25 MHz.
- TIMEOUT_CYCLES, 375000: maximum CLK cycles between consecutive device clock falling edges, and from request to first edge; 15 ms at 25 MHz.
- SYNC_STAGES, 2: flip-flop synchroniser depth on PS2_CLK_IN and PS2_DATA_IN.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous reset, active-high.
- tx_data  input  8  command byte to send.
- tx_valid  input  1  request to send; accepted when tx_valid and tx_ready are both high.
- tx_ready  output  1  high only in IDLE.
- busy  output  1  high in every state except IDLE.
- tx_done  output  1  one-cycle pulse on successful completion.
- tx_error  output  1  one-cycle pulse on timeout or NACK.
- PS2_CLK_IN  input  1  sensed PS/2 clock line.
- PS2_DATA_IN  input  1  sensed PS/2 data line.
- PS2_CLK_OE  output  1  1 = drive clock line low; 0 = release.
- PS2_DATA_OE  output  1  1 = drive data line low; 0 = release.

Behaviour:
- Reset (asynchronous, RST=1): state IDLE; PS2_CLK_OE=0, PS2_DATA_OE=0; tx_ready=1; busy=0; tx_done=0; tx_error=0; all counters and shift register cleared.
- Reset mid-transfer releases both lines immediately, with no completion or error pulse.
- Synchronisation: both PS/2 inputs pass SYNC_STAGES flops. A falling edge is synced previous=1 and current=0. All bit timing uses only synced falling edges.
- IDLE: on accept, latch tx_data and compute parity P = ~^tx_data (odd parity). Go to INHIBIT next cycle.
- INHIBIT: PS2_CLK_OE=1 for exactly INHIBIT_CYCLES cycles, then go to REQUEST.
- REQUEST (entry cycle):
  - PS2_DATA_OE=1 (start bit 0) and PS2_CLK_OE=0.
  - Wait for device falling edge 1, then go to SHIFT.
- SHIFT: at falling edge k, set data for the device's next rising-edge sample:
  - k=1..8: PS2_DATA_OE = ~tx_data[k-1], sent LSB first.
  - k=9: PS2_DATA_OE = ~P.
  - k=10: PS2_DATA_OE=0 (stop bit released); go to ACK.
- ACK: at falling edge 11, sample synced data. Go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait until synced clock and data are both 1.
  - Then pulse tx_done, or tx_error if a NACK was recorded.
  - Return to IDLE.
- Timeout:
  - Counter cleared on REQUEST entry and on every synced falling edge.
  - In REQUEST, SHIFT, ACK and WAIT_IDLE, reaching TIMEOUT_CYCLES releases both OEs, pulses tx_error and returns to IDLE.
- tx_done and tx_error are never asserted in the same cycle.
- tx_valid while busy is ignored: no latch, no queue.
- tx_data may change after accept without effect.
- A falling edge seen in INHIBIT (device contention) is ignored; the inhibit time is not extended.
- Driving rule: never drive a line high. An OE of 0 always means released.

Optional Feature:
- Macro PS2_TX_ACK_CHECK_EN.
- Defined: data sampled at falling edge 11 must be 0. If it is 1, record NACK; WAIT_IDLE then ends with tx_error instead of tx_done.
- Not defined: the ACK sample is ignored, and WAIT_IDLE always ends with tx_done unless a timeout occurs. Timeout behaviour is unchanged.

Test Plan:
- Send 0xED (INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200); device model clocks 11 falls and ACKs low -> PS2_CLK_OE high exactly 20 cycles; line data at falls 1..10 = 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1; one tx_done pulse; tx_ready returns to 1.
- Send 0xF4 -> data bits 0,0,1,0,1,1,1,1; parity 0; tx_done pulses once.
- Device never clocks after REQUEST -> both OEs 0 and tx_error pulse exactly TIMEOUT_CYCLES cycles after REQUEST entry; tx_done stays 0.
- With PS2_TX_ACK_CHECK_EN, device leaves data high at fall 11 -> tx_error pulse after lines idle. Without the macro, the same stimulus -> tx_done pulse.
- Assert RST at falling edge 5 of a 0xFF send -> OEs 0 in the same cycle; tx_done and tx_error stay 0; a new 0xF4 request after release completes normally.
- Pulse tx_valid with 0x00 while busy sending 0xED -> ignored; the 0xED bit sequence is unaffected and exactly one tx_done pulse follows.
